traffic_light_sequencer: RTL and testbench

//  Downstream consumer of the menu controller: runs the two-way (NS/EW) traffic-light cycle.

---
 rtl/traffic_light_sequencer.sv | 176 +++++++++++++++++
 tb/tb_traffic_light_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_sequencer.sv
// Two-way (NS/EW) traffic-light sequencer driven by a 1 s tick prescaler and the menu's sim_state.
// Optional build macro PAUSE_BLINK_EN: both directions blink yellow while paused.
module traffic_light_sequencer #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int BLINK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] sim_state,
    input  logic [7:0] green_duration,
    input  logic [7:0] yellow_duration,
    input  logic [7:0] red_holding,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [2:0] phase,
    output logic [7:0] sec_remaining,
    output logic       tick_1hz
);

    typedef enum logic [2:0] {
        RED_A  = 3'd0,
        NS_GRN = 3'd1,
        NS_YEL = 3'd2,
        RED_B  = 3'd3,
        EW_GRN = 3'd4,
        EW_YEL = 3'd5
    } phase_e;

    localparam int          PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);

    phase_e          phase_q, phase_d, phase_nxt;
    logic [7:0]      sec_q, sec_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [7:0]      load_val;
    logic [2:0]      ns_dec, ew_dec;
    logic            is_play, is_pause, tick;

    assign is_play  = (sim_state == 2'd1);
    assign is_pause = (sim_state == 2'd2);

    function automatic logic [7:0] at_least_one(input logic [7:0] v);
        return (v == 8'd0) ? 8'd1 : v;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= RED_A;
            sec_q   <= 8'd0;
            presc_q <= '0;
        end else begin
            phase_q <= phase_d;
            sec_q   <= sec_d;
            presc_q <= presc_d;
        end
    end

    always_comb begin
        phase_nxt = RED_A;
        case (phase_q)
            RED_A:   phase_nxt = NS_GRN;
            NS_GRN:  phase_nxt = NS_YEL;
            NS_YEL:  phase_nxt = RED_B;
            RED_B:   phase_nxt = EW_GRN;
            EW_GRN:  phase_nxt = EW_YEL;
            EW_YEL:  phase_nxt = RED_A;
            default: phase_nxt = RED_A;
        endcase
    end

    // Duration of the phase being entered; zero settings still give a one-second phase.
    always_comb begin
        load_val = at_least_one(red_holding);
        case (phase_nxt)
            NS_GRN, EW_GRN: load_val = at_least_one(green_duration);
            NS_YEL, EW_YEL: load_val = at_least_one(yellow_duration);
            default:        load_val = at_least_one(red_holding);
        endcase
    end

    always_comb begin
        phase_d = phase_q;
        sec_d   = sec_q;
        presc_d = presc_q;
        tick    = 1'b0;
        if (is_play) begin
            tick    = (presc_q == TICK_MAX);
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
                if (sec_q > 8'd1) begin
                    sec_d = sec_q - 8'd1;
                end else begin
                    phase_d = phase_nxt;
                    sec_d   = load_val;
                end
            end
        end else if (!is_pause) begin
            phase_d = RED_A;
            presc_d = '0;
            sec_d   = at_least_one(red_holding);
        end
        // Codes 6 and 7 can only come from an upset; fall back to all-red.
        if (phase_q > EW_YEL) begin
            phase_d = RED_A;
        end
    end

    always_comb begin
        ns_dec = 3'b100;
        ew_dec = 3'b100;
        case (phase_q)
            NS_GRN:  ns_dec = 3'b001;
            NS_YEL:  ns_dec = 3'b010;
            EW_GRN:  ew_dec = 3'b001;
            EW_YEL:  ew_dec = 3'b010;
            default: begin
                ns_dec = 3'b100;
                ew_dec = 3'b100;
            end
        endcase
    end

`ifdef PAUSE_BLINK_EN
    localparam int            BW        = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_on_q, blink_on_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    // Held at lit/zero outside PAUSE so every pause starts with yellow showing.
    always_comb begin
        blink_cnt_d = '0;
        blink_on_d  = 1'b1;
        if (is_pause) begin
            blink_on_d  = blink_on_q;
            blink_cnt_d = blink_cnt_q + BW'(1);
            if (blink_cnt_q == BLINK_MAX) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end
        end
    end

    always_comb begin
        ns_light = ns_dec;
        ew_light = ew_dec;
        if (is_pause) begin
            ns_light = blink_on_q ? 3'b010 : 3'b000;
            ew_light = blink_on_q ? 3'b010 : 3'b000;
        end
    end
`else
    always_comb begin
        ns_light = ns_dec;
        ew_light = ew_dec;
    end
`endif

    assign phase         = phase_q;
    assign sec_remaining = sec_q;
    assign tick_1hz      = tick;

    a_lamps_safe : assert property (@(posedge clk) disable iff (!reset_n)
        $onehot(ns_dec) && $onehot(ew_dec) && (ns_dec[2] || ew_dec[2]));

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Self-checking bench: table of {inputs, expected outputs} vectors through a scoreboard queue,
// plus hand-written tick, pause, blink and asynchronous-reset sequences.
module tb_traffic_light_sequencer;

    localparam int STOP  = 0;
    localparam int PLAY  = 1;
    localparam int PAUSE = 2;

    logic       clk;
    logic       reset_n;
    logic [1:0] sim_state;
    logic [7:0] green_duration, yellow_duration, red_holding;
    logic [2:0] ns_light, ew_light, phase;
    logic [7:0] sec_remaining;
    logic       tick_1hz;

    traffic_light_sequencer #(.TICK_DIV(4), .BLINK_DIV(2)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .sim_state       (sim_state),
        .green_duration  (green_duration),
        .yellow_duration (yellow_duration),
        .red_holding     (red_holding),
        .ns_light        (ns_light),
        .ew_light        (ew_light),
        .phase           (phase),
        .sec_remaining   (sec_remaining),
        .tick_1hz        (tick_1hz)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int mode;
        int grn;
        int yel;
        int red;
        int cycles;
        int ph;
        int sec;
        int ns;
        int ew;
        int tick;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    function automatic int ns_for(input int ph);
        case (ph)
            1:       return 3'b001;
            2:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic int ew_for(input int ph);
        case (ph)
            4:       return 3'b001;
            5:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic vec_t mk(input int mode, input int grn, input int yel, input int red,
                                input int cycles, input int ph, input int sec, input int tick);
        vec_t v;
        v.mode   = mode;
        v.grn    = grn;
        v.yel    = yel;
        v.red    = red;
        v.cycles = cycles;
        v.ph     = ph;
        v.sec    = sec;
        v.ns     = ns_for(ph);
        v.ew     = ew_for(ph);
        v.tick   = tick;
        return v;
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a negedge: drive inputs, queue the expectation, let the DUT run, return at a negedge.
    task automatic applyStimulus(input vec_t v);
        sim_state       = 2'(v.mode);
        green_duration  = 8'(v.grn);
        yellow_duration = 8'(v.yel);
        red_holding     = 8'(v.red);
        exp_q.push_back(v);
        repeat (v.cycles) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag);
        vec_t e;
        if (exp_q.size() == 0) begin
            cmp({tag, " scoreboard_empty"}, 1, 0);
            return;
        end
        e = exp_q.pop_front();
        cmp({tag, " phase"}, int'(phase), e.ph);
        cmp({tag, " sec"}, int'(sec_remaining), e.sec);
        cmp({tag, " ns"}, int'(ns_light), e.ns);
        cmp({tag, " ew"}, int'(ew_light), e.ew);
        cmp({tag, " tick"}, int'(tick_1hz), e.tick);
    endtask

    initial begin
        vec_t v;
        // STOP release, then one full 184-clk cycle
        vecs.push_back(mk(STOP, 15, 5, 3, 1, 0, 3, 0));
        vecs.push_back(mk(PLAY, 15, 5, 3, 12, 1, 15, 0));
        vecs.push_back(mk(PLAY, 15, 5, 3, 4, 1, 14, 0));
        vecs.push_back(mk(PLAY, 15, 5, 3, 52, 1, 1, 0));
        vecs.push_back(mk(PLAY, 15, 5, 3, 4, 2, 5, 0));
        vecs.push_back(mk(PLAY, 15, 5, 3, 20, 3, 3, 0));
        vecs.push_back(mk(PLAY, 15, 5, 3, 12, 4, 15, 0));
        vecs.push_back(mk(PLAY, 15, 5, 3, 60, 5, 5, 0));
        vecs.push_back(mk(PLAY, 15, 5, 3, 20, 0, 3, 0));
        vecs.push_back(mk(PLAY, 15, 5, 3, 3, 0, 3, 1));
        vecs.push_back(mk(PLAY, 15, 5, 3, 1, 0, 2, 0));
        vecs.push_back(mk(STOP, 15, 5, 3, 1, 0, 3, 0));
        // pause mid-prescaler in NS_GRN with 9 s left
        vecs.push_back(mk(PLAY, 15, 5, 3, 38, 1, 9, 0));
        v = mk(PAUSE, 15, 5, 3, 20, 1, 9, 0);
`ifdef PAUSE_BLINK_EN
        v.ns = 3'b010;
        v.ew = 3'b010;
`endif
        vecs.push_back(v);
        vecs.push_back(mk(PLAY, 15, 5, 3, 1, 1, 9, 1));
        vecs.push_back(mk(PLAY, 15, 5, 3, 1, 1, 8, 0));
        vecs.push_back(mk(STOP, 15, 5, 3, 1, 0, 3, 0));
        // green edited mid NS_GRN
        vecs.push_back(mk(PLAY, 15, 5, 3, 12, 1, 15, 0));
        vecs.push_back(mk(PLAY, 7, 5, 3, 56, 1, 1, 0));
        vecs.push_back(mk(PLAY, 7, 5, 3, 4, 2, 5, 0));
        vecs.push_back(mk(PLAY, 7, 5, 3, 20, 3, 3, 0));
        vecs.push_back(mk(PLAY, 7, 5, 3, 12, 4, 7, 0));
        vecs.push_back(mk(PLAY, 7, 5, 3, 28, 5, 5, 0));
        vecs.push_back(mk(STOP, 15, 5, 3, 1, 0, 3, 0));
        // yellow 0 then 1, with a 1 s green
        vecs.push_back(mk(PLAY, 1, 0, 3, 12, 1, 1, 0));
        vecs.push_back(mk(PLAY, 1, 0, 3, 4, 2, 1, 0));
        vecs.push_back(mk(PLAY, 1, 0, 3, 4, 3, 3, 0));
        vecs.push_back(mk(STOP, 1, 1, 3, 1, 0, 3, 0));
        vecs.push_back(mk(PLAY, 1, 1, 3, 12, 1, 1, 0));
        vecs.push_back(mk(PLAY, 1, 1, 3, 4, 2, 1, 0));
        vecs.push_back(mk(PLAY, 1, 1, 3, 4, 3, 3, 0));
        vecs.push_back(mk(STOP, 15, 5, 3, 1, 0, 3, 0));
        // stop mid EW_YEL, zero red hold, sim_state 3
        vecs.push_back(mk(PLAY, 15, 5, 3, 164, 5, 5, 0));
        vecs.push_back(mk(PLAY, 15, 5, 3, 8, 5, 3, 0));
        vecs.push_back(mk(STOP, 15, 5, 3, 1, 0, 3, 0));
        vecs.push_back(mk(STOP, 15, 5, 0, 1, 0, 1, 0));
        vecs.push_back(mk(PLAY, 15, 5, 0, 4, 1, 15, 0));
        vecs.push_back(mk(3, 15, 5, 3, 1, 0, 3, 0));

        reset_n         = 1'b0;
        sim_state       = 2'(STOP);
        green_duration  = 8'd15;
        yellow_duration = 8'd5;
        red_holding     = 8'd3;
        @(negedge clk);
        exp_q.push_back(mk(STOP, 15, 5, 3, 0, 0, 0, 0));
        checkOutput("reset");
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i));
        end

        // tick pulses on PLAY clks 3, 7 and 11
        sim_state = 2'(PLAY);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            cmp($sformatf("tick_clk%0d", i + 1), int'(tick_1hz),
                ((i == 2) || (i == 6) || (i == 10)) ? 1 : 0);
        end
        cmp("tick_seq phase", int'(phase), 1);

        // pause: everything frozen, no ticks, lamps blink in the blink build
        sim_state = 2'(PAUSE);
        #1;
`ifdef PAUSE_BLINK_EN
        cmp("pause_entry ns", int'(ns_light), 3'b010);
`else
        cmp("pause_entry ns", int'(ns_light), 3'b001);
`endif
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            cmp($sformatf("pause%0d tick", k), int'(tick_1hz), 0);
            cmp($sformatf("pause%0d sec", k), int'(sec_remaining), 15);
`ifdef PAUSE_BLINK_EN
            cmp($sformatf("pause%0d ns", k), int'(ns_light), ((((k + 1) / 2) % 2) == 0) ? 3'b010 : 3'b000);
            cmp($sformatf("pause%0d ew", k), int'(ew_light), ((((k + 1) / 2) % 2) == 0) ? 3'b010 : 3'b000);
`else
            cmp($sformatf("pause%0d ns", k), int'(ns_light), 3'b001);
            cmp($sformatf("pause%0d ew", k), int'(ew_light), 3'b100);
`endif
        end
        @(negedge clk);
        sim_state = 2'(PLAY);
        #1;
        cmp("resume ns", int'(ns_light), 3'b001);
        cmp("resume ew", int'(ew_light), 3'b100);

        // asynchronous reset between clock edges
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        cmp("async_rst phase", int'(phase), 0);
        cmp("async_rst sec", int'(sec_remaining), 0);
        cmp("async_rst ns", int'(ns_light), 3'b100);
        cmp("async_rst ew", int'(ew_light), 3'b100);
        cmp("async_rst tick", int'(tick_1hz), 0);
        @(negedge clk);
        sim_state = 2'(STOP);
        reset_n   = 1'b1;
        @(negedge clk);
        cmp("post_rst sec", int'(sec_remaining), 3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
